// File: rtl/average_stream_reader.sv
// average_stream_reader
// Consumer of the moving-average filter output. The incoming two's-complement
// average stream is decimated by DECIM, and each kept sample is converted to a
// C_DATA_WIDTH-bit word. The word is buffered in a 2^FIFO_AW-deep FIFO and
// presented on a valid/ready handshake. A kept sample that finds the FIFO full,
// with no pop in the same cycle, is counted as a drop.
//
// Optional feature macro: AVG_RD_SATURATE_EN
//   defined   : out-of-range samples clamp to the largest/smallest output word
//   undefined : plain truncation to the low C_DATA_WIDTH bits
module average_stream_reader #(
    parameter int IN_WIDTH     = 26,
    parameter int C_DATA_WIDTH = 16,
    parameter int DECIM        = 10,
    parameter int FIFO_AW      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IN_WIDTH-1:0]     avg_in,
    input  logic                    avg_in_valid,
    output logic [C_DATA_WIDTH-1:0] m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [FIFO_AW:0]        fifo_level,
    output logic [15:0]             drop_count,
    output logic                    overflow
);

    localparam int               DEPTH      = 1 << FIFO_AW;
    localparam logic [9:0]       DCNT_LAST  = 10'(DECIM - 1);
    localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);

    // Decimation and conversion stage
    logic [9:0]              dcnt_r;
    logic                    keep_s;
    logic [C_DATA_WIDTH-1:0] conv_word_s;
    logic [C_DATA_WIDTH-1:0] conv_data_r;
    logic                    conv_valid_r;

    // FIFO state
    logic [C_DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [FIFO_AW-1:0]      wr_ptr_r;
    logic [FIFO_AW-1:0]      rd_ptr_r;
    logic [FIFO_AW:0]        level_r;
    logic [FIFO_AW:0]        level_nxt_s;
    logic                    empty_s;
    logic                    full_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    drop_s;
    logic [15:0]             drop_count_r;
    logic                    overflow_r;

    // A sample is kept when it arrives while the decimation counter sits at zero
    always_comb begin
        keep_s = 1'b0;
        if (avg_in_valid && (dcnt_r == 10'd0)) begin
            keep_s = 1'b1;
        end else begin
            keep_s = 1'b0;
        end
    end

    // Decimation counter: advances on every input strobe, wraps at DECIM-1
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_r <= 10'd0;
        end else if (avg_in_valid) begin
            if (dcnt_r == DCNT_LAST) begin
                dcnt_r <= 10'd0;
            end else begin
                dcnt_r <= dcnt_r + 10'd1;
            end
        end else begin
            dcnt_r <= dcnt_r;
        end
    end

`ifdef AVG_RD_SATURATE_EN
    // Bits above the output sign bit must all equal the sign for the value to fit
    logic [IN_WIDTH-C_DATA_WIDTH:0] sign_ext_s;
    assign sign_ext_s = avg_in[IN_WIDTH-1:C_DATA_WIDTH-1];

    // Clamp out-of-range samples to the most positive / most negative output word
    always_comb begin
        conv_word_s = avg_in[C_DATA_WIDTH-1:0];
        if ((sign_ext_s == {(IN_WIDTH-C_DATA_WIDTH+1){1'b0}}) ||
            (sign_ext_s == {(IN_WIDTH-C_DATA_WIDTH+1){1'b1}})) begin
            conv_word_s = avg_in[C_DATA_WIDTH-1:0];
        end else if (avg_in[IN_WIDTH-1]) begin
            conv_word_s = {1'b1, {(C_DATA_WIDTH-1){1'b0}}};
        end else begin
            conv_word_s = {1'b0, {(C_DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    // Upper input bits are intentionally ignored when truncating
    logic unused_hi_s;
    assign unused_hi_s = ^avg_in[IN_WIDTH-1:C_DATA_WIDTH];

    // Plain truncation: upstream range is known to fit the output word
    always_comb begin
        conv_word_s = avg_in[C_DATA_WIDTH-1:0];
    end
`endif

    // Conversion register: one-cycle valid pulse per kept sample
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_valid_r <= 1'b0;
            conv_data_r  <= {C_DATA_WIDTH{1'b0}};
        end else begin
            conv_valid_r <= keep_s;
            if (keep_s) begin
                conv_data_r <= conv_word_s;
            end else begin
                conv_data_r <= conv_data_r;
            end
        end
    end

    // FIFO control: a full FIFO still accepts a word when it pops in the same cycle
    always_comb begin
        empty_s     = (level_r == {(FIFO_AW+1){1'b0}});
        full_s      = (level_r == LEVEL_FULL);
        pop_s       = (!empty_s) && m_tready;
        push_s      = conv_valid_r && ((!full_s) || pop_s);
        drop_s      = conv_valid_r && (!push_s);
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + (FIFO_AW + 1)'(1);
            2'b01:   level_nxt_s = level_r - (FIFO_AW + 1)'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Storage and write pointer; storage is cleared so m_tdata reads zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {C_DATA_WIDTH{1'b0}};
            end
            wr_ptr_r <= {FIFO_AW{1'b0}};
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= conv_data_r;
            wr_ptr_r        <= wr_ptr_r + FIFO_AW'(1);
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Read pointer and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {FIFO_AW{1'b0}};
            level_r  <= {(FIFO_AW+1){1'b0}};
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            level_r <= level_nxt_s;
        end
    end

    // Drop accounting: saturating counter plus sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count_r <= 16'd0;
            overflow_r   <= 1'b0;
        end else if (drop_s) begin
            if (drop_count_r != 16'hFFFF) begin
                drop_count_r <= drop_count_r + 16'd1;
            end else begin
                drop_count_r <= drop_count_r;
            end
            overflow_r <= 1'b1;
        end else begin
            drop_count_r <= drop_count_r;
            overflow_r   <= overflow_r;
        end
    end

    assign m_tdata    = mem_r[rd_ptr_r];
    assign m_tvalid   = !empty_s;
    assign fifo_level = level_r;
    assign drop_count = drop_count_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_average_stream_reader.sv
// Directed testbench for average_stream_reader. Two instances share clock and
// reset: dut_a runs with DECIM=1, dut_b with DECIM=10. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_average_stream_reader;

    logic        clk;
    logic        rst;

    logic [25:0] a_avg;
    logic        a_valid;
    logic [15:0] a_tdata;
    logic        a_tvalid;
    logic        a_tready;
    logic [4:0]  a_level;
    logic [15:0] a_drops;
    logic        a_ovf;

    logic [25:0] b_avg;
    logic        b_valid;
    logic [15:0] b_tdata;
    logic        b_tvalid;
    logic        b_tready;
    logic [4:0]  b_level;
    logic [15:0] b_drops;
    logic        b_ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] exp_conv[6];
    logic [25:0] conv_in[6];

    average_stream_reader #(.IN_WIDTH(26), .C_DATA_WIDTH(16), .DECIM(1), .FIFO_AW(4)) dut_a (
        .clk(clk), .rst(rst), .avg_in(a_avg), .avg_in_valid(a_valid),
        .m_tdata(a_tdata), .m_tvalid(a_tvalid), .m_tready(a_tready),
        .fifo_level(a_level), .drop_count(a_drops), .overflow(a_ovf)
    );

    average_stream_reader #(.IN_WIDTH(26), .C_DATA_WIDTH(16), .DECIM(10), .FIFO_AW(4)) dut_b (
        .clk(clk), .rst(rst), .avg_in(b_avg), .avg_in_valid(b_valid),
        .m_tdata(b_tdata), .m_tvalid(b_tvalid), .m_tready(b_tready),
        .fifo_level(b_level), .drop_count(b_drops), .overflow(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Record the handshakes that the coming rising edge will complete, then advance
    task automatic tick();
        if (a_tvalid && a_tready) qa.push_back(a_tdata);
        if (b_tvalid && b_tready) qb.push_back(b_tdata);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        rst = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    initial begin
        rst      = 1'b1;
        a_avg    = 26'd0;
        a_valid  = 1'b0;
        a_tready = 1'b0;
        b_avg    = 26'd0;
        b_valid  = 1'b0;
        b_tready = 1'b0;

        conv_in = '{26'h0010000, 26'h3FF0000, 26'h3FFFFFF, 26'h0007FFF, 26'h3FF8000, 26'h0000123};
`ifdef AVG_RD_SATURATE_EN
        exp_conv = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0123};
`else
        exp_conv = '{16'h0000, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0123};
`endif

        @(negedge clk);
        repeat (3) tick();

        // Reset state
        check_value("rst_tvalid", 32'(a_tvalid), 32'd0);
        check_value("rst_tdata",  32'(a_tdata),  32'd0);
        check_value("rst_level",  32'(a_level),  32'd0);
        check_value("rst_drops",  32'(a_drops),  32'd0);
        check_value("rst_ovf",    32'(a_ovf),    32'd0);
        rst = 1'b0;
        repeat (6) tick();

        // Single word: two-cycle latency, one cycle of occupancy with ready high
        a_tready = 1'b1;
        a_avg    = 26'h0000123;
        a_valid  = 1'b1;
        tick();
        a_valid = 1'b0;
        check_value("lat_n1_tvalid", 32'(a_tvalid), 32'd0);
        tick();
        check_value("lat_n2_tvalid", 32'(a_tvalid), 32'd1);
        check_value("lat_n2_tdata",  32'(a_tdata),  32'h0123);
        check_value("lat_n2_level",  32'(a_level),  32'd1);
        tick();
        check_value("lat_n3_level",  32'(a_level),  32'd0);
        check_value("lat_n3_tvalid", 32'(a_tvalid), 32'd0);

        // Decimation by 10 over 25 consecutive samples
        do_reset();
        b_tready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            b_avg   = 26'(k);
            b_valid = 1'b1;
            tick();
        end
        b_valid = 1'b0;
        repeat (6) tick();
        check_value("decim_count", 32'(qb.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < qb.size()) check_value("decim_word", 32'(qb[i]), 32'(i * 10));
            else               check_value("decim_missing", 32'(qb.size()), 32'd3);
        end

        // Conversion rule, back-to-back kept samples
        do_reset();
        a_tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_avg   = conv_in[i];
            a_valid = 1'b1;
            tick();
        end
        a_valid = 1'b0;
        repeat (5) tick();
        check_value("conv_count", 32'(qa.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < qa.size()) check_value("conv_word", 32'(qa[i]), 32'(exp_conv[i]));
            else               check_value("conv_missing", 32'(qa.size()), 32'd6);
        end

        // Overflow: 20 pushes into 16 entries with ready low, then drain
        do_reset();
        a_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a_avg   = 26'(100 + i);
            a_valid = 1'b1;
            tick();
        end
        a_valid = 1'b0;
        repeat (3) tick();
        check_value("ovf_level",  32'(a_level),  32'd16);
        check_value("ovf_drops",  32'(a_drops),  32'd4);
        check_value("ovf_flag",   32'(a_ovf),    32'd1);
        check_value("ovf_tvalid", 32'(a_tvalid), 32'd1);
        check_value("ovf_head",   32'(a_tdata),  32'd100);
        a_tready = 1'b1;
        repeat (20) tick();
        a_tready = 1'b0;
        check_value("drain_count", 32'(qa.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < qa.size()) check_value("drain_word", 32'(qa[i]), 32'(100 + i));
            else               check_value("drain_missing", 32'(qa.size()), 32'd16);
        end
        check_value("drain_ovf",   32'(a_ovf),   32'd1);
        check_value("drain_level", 32'(a_level), 32'd0);
        check_value("drain_drops", 32'(a_drops), 32'd4);

        // Full FIFO with push and pop in the same cycle
        do_reset();
        a_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_avg   = 26'(200 + i);
            a_valid = 1'b1;
            tick();
        end
        a_valid = 1'b0;
        repeat (2) tick();
        check_value("full_level", 32'(a_level), 32'd16);
        a_avg   = 26'd300;
        a_valid = 1'b1;
        tick();
        for (int i = 1; i < 20; i++) begin
            a_avg    = 26'(300 + i);
            a_tready = 1'b1;
            tick();
            check_value("full_pushpop_level", 32'(a_level), 32'd16);
        end
        a_valid = 1'b0;
        repeat (40) tick();
        check_value("full_drops", 32'(a_drops), 32'd0);
        check_value("full_count", 32'(qa.size()), 32'd36);
        for (int i = 0; i < 36; i++) begin
            if (i < qa.size()) check_value("full_word", 32'(qa[i]), (i < 16) ? 32'(200 + i) : 32'(300 + i - 16));
            else               check_value("full_missing", 32'(qa.size()), 32'd36);
        end

        // Reset mid-stream with level 7, drops pending and a sample in flight
        do_reset();
        a_tready = 1'b0;
        b_tready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            a_avg   = 26'(400 + i);
            a_valid = 1'b1;
            b_avg   = 26'(500 + i);
            b_valid = (i < 3);
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (2) tick();
        a_tready = 1'b1;
        repeat (9) tick();
        a_tready = 1'b0;
        tick();
        check_value("mid_level", 32'(a_level), 32'd7);
        check_value("mid_drops", 32'(a_drops), 32'd2);
        rst     = 1'b1;
        a_avg   = 26'h0000555;
        a_valid = 1'b1;
        tick();
        rst     = 1'b0;
        a_valid = 1'b0;
        check_value("mrst_tvalid", 32'(a_tvalid), 32'd0);
        check_value("mrst_level",  32'(a_level),  32'd0);
        check_value("mrst_drops",  32'(a_drops),  32'd0);
        check_value("mrst_ovf",    32'(a_ovf),    32'd0);
        check_value("mrst_tdata",  32'(a_tdata),  32'd0);
        tick();
        check_value("mrst_inflight_level", 32'(a_level), 32'd0);
        qb.delete();
        b_tready = 1'b1;
        b_avg    = 26'h0000077;
        b_valid  = 1'b1;
        tick();
        b_valid = 1'b0;
        repeat (4) tick();
        check_value("mrst_first_kept_count", 32'(qb.size()), 32'd1);
        if (qb.size() > 0) check_value("mrst_first_kept_word", 32'(qb[0]), 32'h77);
        else               check_value("mrst_first_kept_missing", 32'(qb.size()), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/average_stream_reader.md
# average_stream_reader

Consumer side of the moving-average filter output. It accepts the 26-bit two's-complement average stream, which is valid-only with no backpressure, and decimates it by a programmable ratio. Each kept sample is converted to a 16-bit word and buffered in a small FIFO, then presented to the host/DMA path on a valid/ready handshake. It sits between the averaging filter and the data-readout interface, and reports drops when the downstream stalls longer than the buffer can absorb.

## Interface
- IN_WIDTH, 26, width of the incoming average word (two's complement)
- C_DATA_WIDTH, 16, width of the output word
- DECIM, 10, decimation ratio, legal 1..1023; keep 1 of every DECIM input samples
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW words
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- avg_in  input  IN_WIDTH  averaged sample from the filter
- avg_in_valid  input  1  one-cycle strobe per sample; cannot be stalled
- m_tdata  output  C_DATA_WIDTH  output word
- m_tvalid  output  1  m_tdata holds a valid word
- m_tready  input  1  downstream accepts the word this cycle
- fifo_level  output  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW
- drop_count  output  16  number of kept samples lost to a full FIFO; saturates at 0xFFFF
- overflow  output  1  sticky; set on the first drop, cleared only by rst

## Operation
- **Decimation counter** dcnt, range 0..DECIM-1:
  - Advances on each avg_in_valid and wraps from DECIM-1 to 0.
  - A sample is kept when avg_in_valid is high and dcnt==0, so the first sample after reset is always kept.
  - With DECIM=1 every sample is kept.
- **Conversion stage**: a registered stage (conv_data, conv_valid) captures the converted kept sample. The conversion rule is set by the macro described under Configuration. conv_valid is a one-cycle pulse.
- **FIFO write**:
  - On conv_valid the word is written if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped: drop_count increments (saturating) and overflow is set.
- **FIFO read**:
  - m_tvalid = (fifo_level != 0). m_tdata shows the head word combinationally from FIFO storage.
  - A pop occurs when m_tvalid && m_tready.
  - m_tdata and m_tvalid must stay stable while m_tvalid && !m_tready.
- **Simultaneous push and pop**: fifo_level is unchanged and both pointers advance. This applies at any level, including full.
- **Pointers**: FIFO_AW-bit read and write pointers wrap naturally. Full and empty are derived from fifo_level.
- **m_tready asserted while the FIFO is empty**: no effect.
- **rst at any time**, including mid-stream and with the FIFO full, clears dcnt, conv_valid, both pointers, fifo_level, drop_count and overflow. Any in-flight sample is discarded.

## Timing
- Reset values: m_tvalid=0, m_tdata=0 (storage cleared), fifo_level=0, drop_count=0, overflow=0.
- Latency for a kept sample arriving in cycle N into an empty FIFO:
  - conv_valid is high in cycle N+1.
  - The FIFO write occurs at the end of N+1.
  - m_tvalid=1 with the word on m_tdata in cycle N+2.
- A pop in cycle P updates fifo_level and m_tdata in cycle P+1.
- Throughput: one word per cycle sustained, for DECIM=1 with m_tready held high.
- avg_in_valid may be asserted on consecutive cycles. There is no minimum gap.

## Configuration
- Macro: AVG_RD_SATURATE_EN.
- **Defined**: values above 2^(C_DATA_WIDTH-1)-1 clamp to 0x7FFF, and values below -2^(C_DATA_WIDTH-1) clamp to 0x8000. In-range values pass as the low C_DATA_WIDTH bits.
- **Undefined**: plain truncation to avg_in[C_DATA_WIDTH-1:0] with no range check. This saves comparator logic when the upstream range is known to fit.

## Test plan
- **Reset and single word**: DECIM=1, m_tready=1, apply avg_in=0x0000123 in cycle 10 → m_tvalid=1, m_tdata=0x0123 in cycle 12, fifo_level=1 for exactly that cycle.
- **Decimation**: DECIM=10, 25 consecutive valid samples of value k (k=0..24) → exactly 3 output words, 0, 10, 20, in order.
- **Saturation** (AVG_RD_SATURATE_EN defined):
  - Input 0x0010000 → 0x7FFF.
  - Input 0x3FF0000 (−65536) → 0x8000.
  - Input 0x3FFFFFF → 0xFFFF.
  - Without the macro, 0x0010000 → 0x0000.
- **Overflow**: DECIM=1, FIFO_AW=4, m_tready=0, push 20 samples → fifo_level=16, drop_count=4, overflow=1. Then raise m_tready → the first 16 samples drain in order and overflow stays 1.
- **Full with simultaneous push/pop**: with the FIFO full and m_tready=1 continuously, a sample is pushed each cycle → no drops and fifo_level stays 16.
- **Reset mid-stream**: with fifo_level=7, assert rst for 1 cycle → the next cycle shows m_tvalid=0, fifo_level=0, drop_count=0. The next kept sample is the first valid after reset.
